// File: rtl/sha256_pkg.sv
// SHA-256 shared types and schedule helper functions.
// Used by the message schedule and the compression round engine.
package sha256_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [511:0] block_t;

   localparam int SHA256_ROUNDS = 64;
   localparam int SHA256_WIN    = 16;
   localparam int SHA256_IDX_W  = 6;

   typedef enum logic {
      S_IDLE,
      S_EXPAND
   } sched_state_e;

   // Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3.
   function automatic word_t sha256_sigma0(input word_t x);
      word_t r7;
      word_t r18;
      r7  = {x[6:0], x[31:7]};
      r18 = {x[17:0], x[31:18]};
      return r7 ^ r18 ^ (x >> 3);
   endfunction

   // Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10.
   function automatic word_t sha256_sigma1(input word_t x);
      word_t r17;
      word_t r19;
      r17 = {x[16:0], x[31:17]};
      r19 = {x[18:0], x[31:19]};
      return r17 ^ r19 ^ (x >> 10);
   endfunction

   // Word i of a block, W0 in the top 32 bits.
   function automatic word_t sha256_block_word(input block_t b,
                                               input int     i);
      return b[511-32*i -: 32];
   endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// One-entry block register slice (data, ID, last).
// A write and a drain in the same cycle are both taken.
module sha256_block_buffer
   import sha256_pkg::*;
#(
   parameter int ID_W = 6
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            sync_rst,
   input  logic            wr_valid,
   input  block_t          wr_data,
   input  logic [ID_W-1:0] wr_id,
   input  logic            wr_last,
   output logic            rd_valid,
   input  logic            rd_ready,
   output block_t          rd_data,
   output logic [ID_W-1:0] rd_id,
   output logic            rd_last
);

   logic            full_q;
   block_t          data_q;
   logic [ID_W-1:0] id_q;
   logic            last_q;

   assign rd_valid = full_q;
   assign rd_data  = data_q;
   assign rd_id    = id_q;
   assign rd_last  = last_q;

   // Occupancy: a write refills even while the old entry drains.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         full_q <= 1'b0;
      end else if (sync_rst) begin
         full_q <= 1'b0;
      end else if (wr_valid) begin
         full_q <= 1'b1;
      end else if (rd_ready && full_q) begin
         full_q <= 1'b0;
      end
   end

   // Payload capture on write.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data_q <= '0;
         id_q   <= '0;
         last_q <= 1'b0;
      end else if (sync_rst) begin
         data_q <= '0;
         id_q   <= '0;
         last_q <= 1'b0;
      end else if (wr_valid) begin
         data_q <= wr_data;
         id_q   <= wr_id;
         last_q <= wr_last;
      end
   end

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: 16-word sliding window emitting W0..W63.
// SHA256_MSG_SCHED_BUF_EN adds a one-block buffer for back-to-back blocks.
module sha256_message_schedule
   import sha256_pkg::*;
#(
   parameter int ID_W = 6
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    en,
   input  logic                    sync_rst,
   input  block_t                  data_in,
   input  logic [ID_W-1:0]         data_in_id,
   input  logic                    data_in_last,
   input  logic                    data_in_valid,
   output logic                    data_in_ready,
   output word_t                   data_out,
   output logic [SHA256_IDX_W-1:0] data_out_idx,
   output logic [ID_W-1:0]         data_out_id,
   output logic                    data_out_last,
   output logic                    data_out_valid,
   input  logic                    data_out_ready
);

   localparam logic [SHA256_IDX_W-1:0] T_LAST =
      SHA256_IDX_W'(SHA256_ROUNDS - 1);

   sched_state_e            state_q;
   sched_state_e            state_d;
   word_t                   win_q [SHA256_WIN];
   logic [SHA256_IDX_W-1:0] t_q;
   logic [ID_W-1:0]         id_q;
   logic                    last_q;

   logic                    in_hs;
   logic                    out_hs;
   logic                    end_hs;
   logic                    load;
   block_t                  ld_data;
   logic [ID_W-1:0]         ld_id;
   logic                    ld_last;
   word_t                   w_new;

   assign data_out_valid = en & (state_q == S_EXPAND);
   assign in_hs          = data_in_valid & data_in_ready;
   assign out_hs         = data_out_valid & data_out_ready;
   assign end_hs         = out_hs & (t_q == T_LAST);

   assign data_out      = win_q[0];
   assign data_out_idx  = t_q;
   assign data_out_id   = id_q;
   assign data_out_last = last_q & (t_q == T_LAST);

   assign w_new = sha256_sigma1(win_q[14]) + win_q[9] +
                  sha256_sigma0(win_q[1]) + win_q[0];

`ifdef SHA256_MSG_SCHED_BUF_EN

   logic            buf_full;
   logic            load_slot;
   logic            bypass;
   logic            buf_wr;
   block_t          buf_data;
   logic [ID_W-1:0] buf_id;
   logic            buf_last;

   // A window slot opens in IDLE or on the final word's handshake.
   // With an empty buffer the incoming block goes straight to the
   // window; otherwise it is parked and the parked one is loaded.
   assign data_in_ready = en & ~buf_full;
   assign load_slot     = (en & (state_q == S_IDLE)) | end_hs;
   assign bypass        = load_slot & ~buf_full;
   assign buf_wr        = in_hs & ~bypass;
   assign load          = (load_slot & buf_full) | (bypass & in_hs);
   assign ld_data       = buf_full ? buf_data : data_in;
   assign ld_id         = buf_full ? buf_id   : data_in_id;
   assign ld_last       = buf_full ? buf_last : data_in_last;

   sha256_block_buffer #(
      .ID_W(ID_W)
   ) u_buf (
      .clk     (clk),
      .nrst    (nrst),
      .sync_rst(sync_rst),
      .wr_valid(buf_wr),
      .wr_data (data_in),
      .wr_id   (data_in_id),
      .wr_last (data_in_last),
      .rd_valid(buf_full),
      .rd_ready(load_slot),
      .rd_data (buf_data),
      .rd_id   (buf_id),
      .rd_last (buf_last)
   );

`else

   assign data_in_ready = en & (state_q == S_IDLE);
   assign load          = in_hs;
   assign ld_data       = data_in;
   assign ld_id         = data_in_id;
   assign ld_last       = data_in_last;

`endif

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
      end else if (sync_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a reload on the final word keeps us in EXPAND.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (load) state_d = S_EXPAND;
         end
         S_EXPAND: begin
            if (end_hs && !load) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Window load / shift-and-expand, index and block tags.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < SHA256_WIN; i++) win_q[i] <= '0;
         t_q    <= '0;
         id_q   <= '0;
         last_q <= 1'b0;
      end else if (sync_rst) begin
         for (int i = 0; i < SHA256_WIN; i++) win_q[i] <= '0;
         t_q    <= '0;
         id_q   <= '0;
         last_q <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < SHA256_WIN; i++) begin
            win_q[i] <= sha256_block_word(ld_data, i);
         end
         t_q    <= '0;
         id_q   <= ld_id;
         last_q <= ld_last;
      end else if (out_hs && !end_hs) begin
         for (int i = 0; i < SHA256_WIN - 1; i++) win_q[i] <= win_q[i+1];
         win_q[SHA256_WIN-1] <= w_new;
         t_q <= t_q + 1'b1;
      end
   end

endmodule
